// File: rtl/ddr3_ui_pkg.sv
// Shared definitions for the DDR3 user-interface BRAM responder:
// user command codes, internal queue opcode and command-queue entry width.
package ddr3_ui_pkg;

    // Command codes driven by the initiator on the cmd port
    localparam logic [2:0] CMD_WR = 3'd0;
    localparam logic [2:0] CMD_RD = 3'd1;

    // Opcode stored in the command queue (illegal codes never get this far)
    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } op_e;

    localparam int CQ_OP_W = 1;

    // Width of one command-queue entry {op, bram index}
    function automatic int cq_entry_w(input int mem_aw);
        return CQ_OP_W + mem_aw;
    endfunction

endpackage

// File: rtl/ddr3_ui_sync_fifo.sv
// Single-clock FIFO with full/empty flags and a show-ahead head word.
// DEPTH must be a power of two (>= 2). Push while full and pop while empty
// are ignored. Storage is not reset; only the pointers and the count are.
module ddr3_ui_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr_q];

    // Next pointer and occupancy from the qualified push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Control state, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ddr3_ui_bram_responder.sv
// Memory-side responder for the DDR3 IP user command/data port, backed by
// inferred block RAM. Commands and write data are queued independently and
// paired in FIFO order; one queue-head op executes per cycle in accept order.
// Reads return after a fixed RD_LAT-cycle pipe.
// Optional build macro: UI_REFRESH_STALL_EN -- periodically holds cmd_ready
// low for 8 of every 512 cycles after calibration to emulate refresh.
module ddr3_ui_bram_responder
    import ddr3_ui_pkg::*;
#(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int MEM_AW       = 10,
    parameter int CQ_DEPTH     = 4,
    parameter int WQ_DEPTH     = 4,
    parameter int RD_LAT       = 4,
    parameter int CALIB_CYCLES = 64
) (
    input  logic                ui_clk,
    input  logic                ui_clk_sync_rst,
    output logic                cmd_ready,
    input  logic [2:0]          cmd,
    input  logic                cmd_en,
    input  logic [ADDR_W-1:0]   addr,
    output logic                wr_data_rdy,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_data_en,
    input  logic                wr_data_end,
    input  logic [DATA_W/8-1:0] wr_data_mask,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_data_valid,
    output logic                rd_data_end,
    output logic                init_calib_complete
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(CALIB_CYCLES + 1);
    localparam int CQ_W  = cq_entry_w(MEM_AW);

    typedef struct packed {
        op_e               op;
        logic [MEM_AW-1:0] idx;
    } cq_entry_t;

    logic                   calib_q, calib_d;
    logic [CNT_W-1:0]       calib_cnt_q, calib_cnt_d;
    logic                   stall;
    logic                   cq_full, cq_empty, wq_full, wq_empty;
    logic                   cq_push, wq_push, exec_wr, exec_rd;
    cq_entry_t              cq_in, cq_head;
    logic [BE_W+DATA_W-1:0] wq_head;
    logic [RD_LAT-2:0]      vld_q, vld_d;
    logic [DATA_W-1:0]      dat_q [RD_LAT-1];
    logic                   rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]      rd_data_q, rd_data_d;
    logic [DATA_W-1:0]      mem [2**MEM_AW];
    logic                   unused_ok;

    // wr_data_end carries no information with one beat per command; upper
    // and sub-burst address bits alias onto the BRAM index.
    assign unused_ok = ^{wr_data_end, addr};

    assign cmd_ready   = calib_q & ~cq_full & ~stall;
    assign wr_data_rdy = calib_q & ~wq_full;
    assign cq_push     = cmd_en & cmd_ready & ((cmd == CMD_WR) || (cmd == CMD_RD));
    assign wq_push     = wr_data_en & wr_data_rdy;

    // A write at the head waits for its data; a read goes immediately
    assign exec_rd = ~ui_clk_sync_rst & ~cq_empty & (cq_head.op == OP_RD);
    assign exec_wr = ~ui_clk_sync_rst & ~cq_empty & (cq_head.op == OP_WR) & ~wq_empty;

    // Command-queue entry from the accepted command
    always_comb begin
        cq_in.op  = (cmd == CMD_RD) ? OP_RD : OP_WR;
        cq_in.idx = addr[MEM_AW+2:3];
    end

    ddr3_ui_sync_fifo #(.DATA_W(CQ_W), .DEPTH(CQ_DEPTH)) u_cmd_q (
        .clk   (ui_clk),
        .rst   (ui_clk_sync_rst),
        .push  (cq_push),
        .wdata (cq_in),
        .pop   (exec_rd | exec_wr),
        .rdata (cq_head),
        .full  (cq_full),
        .empty (cq_empty)
    );

    ddr3_ui_sync_fifo #(.DATA_W(BE_W + DATA_W), .DEPTH(WQ_DEPTH)) u_wdata_q (
        .clk   (ui_clk),
        .rst   (ui_clk_sync_rst),
        .push  (wq_push),
        .wdata ({wr_data_mask, wr_data}),
        .pop   (exec_wr),
        .rdata (wq_head),
        .full  (wq_full),
        .empty (wq_empty)
    );

`ifdef UI_REFRESH_STALL_EN
    logic [8:0] stall_cnt_q, stall_cnt_d;

    assign stall = calib_q & (stall_cnt_q < 9'd8);

    // Free-running refresh-window counter, started by calibration
    always_comb begin
        stall_cnt_d = calib_q ? stall_cnt_q + 9'd1 : '0;
    end

    // Refresh counter register
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) stall_cnt_q <= '0;
        else                 stall_cnt_q <= stall_cnt_d;
    end
`else
    assign stall = 1'b0;
`endif

    // Calibration countdown and read-pipe next state
    always_comb begin
        calib_cnt_d = calib_cnt_q;
        calib_d     = calib_q;
        if (!calib_q) begin
            calib_cnt_d = calib_cnt_q + CNT_W'(1);
            if (calib_cnt_q == CNT_W'(CALIB_CYCLES - 1)) calib_d = 1'b1;
        end
        vld_d[0] = exec_rd;
        for (int i = 1; i < RD_LAT - 1; i++) vld_d[i] = vld_q[i-1];
        rd_valid_d = vld_q[RD_LAT-2];
        rd_data_d  = vld_q[RD_LAT-2] ? dat_q[RD_LAT-2] : rd_data_q;
    end

    // Control registers and the output stage, all cleared by reset
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            calib_q     <= 1'b0;
            calib_cnt_q <= '0;
            vld_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            calib_q     <= calib_d;
            calib_cnt_q <= calib_cnt_d;
            vld_q       <= vld_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // BRAM with byte-enable write, registered read, then data padding to RD_LAT
    always_ff @(posedge ui_clk) begin
        if (exec_wr) begin
            for (int b = 0; b < BE_W; b++) begin
                if (!wq_head[DATA_W+b]) mem[cq_head.idx][b*8 +: 8] <= wq_head[b*8 +: 8];
            end
        end
        if (exec_rd) dat_q[0] <= mem[cq_head.idx];
        for (int i = 1; i < RD_LAT - 1; i++) dat_q[i] <= dat_q[i-1];
    end

    assign rd_data             = rd_data_q;
    assign rd_data_valid       = rd_valid_q;
    assign rd_data_end         = rd_valid_q;
    assign init_calib_complete = calib_q;

endmodule

// File: tb/tb_ddr3_ui_bram_responder.sv
// Scoreboard bench for ddr3_ui_bram_responder: stimulus tasks feed a
// transaction-level memory model that pushes expected read data into a
// queue; an independent monitor pops and compares on every rd_data_valid.
module tb_ddr3_ui_bram_responder;
    import ddr3_ui_pkg::*;

    localparam int ADDR_W    = 28;
    localparam int DATA_W    = 128;
    localparam int MEM_AW    = 10;
    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam int RD_LAT    = 4;
    localparam int CALIB     = 64;

    logic              clk;
    logic              rst;
    logic              cmd_ready;
    logic [2:0]        cmd;
    logic              cmd_en;
    logic [ADDR_W-1:0] addr;
    logic              wr_data_rdy;
    logic [DATA_W-1:0] wr_data;
    logic              wr_data_en;
    logic              wr_data_end;
    logic [15:0]       wr_data_mask;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              rd_data_end;
    logic              init_calib_complete;

    ddr3_ui_bram_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .CQ_DEPTH(4),
        .WQ_DEPTH(4), .RD_LAT(RD_LAT), .CALIB_CYCLES(CALIB)
    ) dut (
        .ui_clk              (clk),
        .ui_clk_sync_rst     (rst),
        .cmd_ready           (cmd_ready),
        .cmd                 (cmd),
        .cmd_en              (cmd_en),
        .addr                (addr),
        .wr_data_rdy         (wr_data_rdy),
        .wr_data             (wr_data),
        .wr_data_en          (wr_data_en),
        .wr_data_end         (wr_data_end),
        .wr_data_mask        (wr_data_mask),
        .rd_data             (rd_data),
        .rd_data_valid       (rd_data_valid),
        .rd_data_end         (rd_data_end),
        .init_calib_complete (init_calib_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void check(input string name, input logic [DATA_W-1:0] act,
                                  input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Reference model: the memory as an array, commands executed in accept
    // order the moment their write data is available.
    typedef struct {
        bit rd;
        int idx;
    } mcmd_t;

    logic [DATA_W-1:0] mmem [MEM_DEPTH];
    mcmd_t             mcmd_q[$];
    logic [DATA_W-1:0] mdat_q[$];
    logic [15:0]       mmsk_q[$];
    logic [DATA_W-1:0] exp_q[$];

    function automatic void model_run();
        while (mcmd_q.size() > 0) begin
            if (mcmd_q[0].rd) begin
                exp_q.push_back(mmem[mcmd_q[0].idx]);
                mcmd_q.delete(0);
            end else if (mdat_q.size() > 0) begin
                for (int b = 0; b < 16; b++)
                    if (!mmsk_q[0][b]) mmem[mcmd_q[0].idx][b*8 +: 8] = mdat_q[0][b*8 +: 8];
                mcmd_q.delete(0);
                mdat_q.delete(0);
                mmsk_q.delete(0);
            end else begin
                return;
            end
        end
    endfunction

    function automatic void model_cmd(input logic [2:0] c, input logic [ADDR_W-1:0] a);
        if (c == CMD_WR || c == CMD_RD) begin
            mcmd_q.push_back('{rd: (c == CMD_RD), idx: int'((a >> 3) % MEM_DEPTH)});
            model_run();
        end
    endfunction

    function automatic void model_data(input logic [DATA_W-1:0] d, input logic [15:0] m);
        mdat_q.push_back(d);
        mmsk_q.push_back(m);
        model_run();
    endfunction

    // Monitor: every valid beat must match the oldest expectation; idle
    // cycles must hold the previous data with rd_data_end low.
    logic [DATA_W-1:0] last_rd;
    always @(negedge clk) begin
        if (rst) begin
            last_rd = '0;
        end else if (rd_data_valid) begin
            check("rd_data_end_on_valid", rd_data_end, 1);
            if (exp_q.size() == 0) check("rd_valid_unexpected", rd_data_valid, 0);
            else                   check("rd_data", rd_data, exp_q.pop_front());
            last_rd = rd_data;
        end else begin
            check("rd_data_end_idle", rd_data_end, 0);
            check("rd_data_hold", rd_data, last_rd);
        end
    end

    // All tasks start and end just after a rising edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [ADDR_W-1:0] a);
        int budget = 2000;
        cmd    = c;
        addr   = a;
        cmd_en = 1'b1;
        while (!cmd_ready && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", cmd_ready, 1);
            cmd_en = 1'b0;
            return;
        end
        @(posedge clk);
        model_cmd(c, a);
        #1;
        cmd_en = 1'b0;
    endtask

    task automatic send_data(input logic [DATA_W-1:0] d, input logic [15:0] m);
        int budget = 2000;
        wr_data      = d;
        wr_data_mask = m;
        wr_data_en   = 1'b1;
        while (!wr_data_rdy && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (!wr_data_rdy) begin
            check("wdata_accept_timeout", wr_data_rdy, 1);
            wr_data_en = 1'b0;
            return;
        end
        @(posedge clk);
        model_data(d, m);
        #1;
        wr_data_en = 1'b0;
    endtask

    task automatic wait_drain();
        int budget = 300;
        while (exp_q.size() > 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        check("drain_pending_reads", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_init_calib", init_calib_complete, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_wr_data_rdy", wr_data_rdy, 0);
        check("rst_rd_valid", rd_data_valid, 0);
        check("rst_rd_end", rd_data_end, 0);
        check("rst_rd_data", rd_data, 0);
    endtask

    // Counts rising edges after reset release; calib must arrive on edge CALIB
    task automatic calib_check();
        for (int k = 1; k <= CALIB + 2; k++) begin
            @(posedge clk);
            #1;
            if (k == CALIB - 1) begin
                check("calib_early", init_calib_complete, 0);
                check("cmd_ready_precal", cmd_ready, 0);
                check("wr_rdy_precal", wr_data_rdy, 0);
            end
            if (k == CALIB) begin
                check("calib_on_time", init_calib_complete, 1);
                check("wr_rdy_after_cal", wr_data_rdy, 1);
            end
        end
    endtask

    function automatic logic [DATA_W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stimulus program
    logic [DATA_W-1:0] d_a, d_b;
    logic [2:0]        op_c[$];
    logic [ADDR_W-1:0] op_a[$];
    logic [DATA_W-1:0] wd_q[$];
    logic [15:0]       wm_q[$];
    int                idx_tab[16];
    int                acc;
    int                lat;

    initial begin
        rst = 1'b1; cmd = '0; cmd_en = 1'b0; addr = '0;
        wr_data = '0; wr_data_en = 1'b0; wr_data_end = 1'b1; wr_data_mask = '0;

        // Reset state and calibration timing
        idle(3);
        check_reset_outputs();
        rst = 1'b0;
        calib_check();

        // Write then read 0x40, with read latency measured from the pop
        d_a = 128'h0123456789ABCDEF0123456789ABCDEF;
        send_data(d_a, 16'h0000);
        send_cmd(CMD_WR, 28'h40);
        idle(3);
        send_cmd(CMD_RD, 28'h40);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rd_data_valid) break;
        end
        // The queue was empty, so the first sampled cycle is the pop cycle
        check("rd_latency", lat, RD_LAT + 1);
        check("t2_rd_data", rd_data, d_a);
        check("t2_rd_end", rd_data_end, 1);
        @(posedge clk);
        #1;
        wait_drain();

        // Write data ahead of its command, immediate read, aliased read
        send_data(rand128(), 16'h0000);
        idle(3);
        send_cmd(CMD_WR, 28'h00000C8);
        send_cmd(CMD_RD, 28'h00000CD);
        send_cmd(CMD_RD, 28'h08000C8);
        wait_drain();

        // Byte-masked overwrite of 0x80
        send_data(rand128(), 16'h0000);
        send_cmd(CMD_WR, 28'h80);
        send_data(rand128(), 16'h00FF);
        send_cmd(CMD_WR, 28'h80);
        send_cmd(CMD_RD, 28'h80);
        wait_drain();

        // Command queue fills at four when writes have no data
        acc    = 0;
        cmd    = CMD_WR;
        for (int cyc = 0; cyc < 10; cyc++) begin
            cmd_en = (acc < 6);
            addr   = 28'h100 + ADDR_W'(acc * 8);
            if (cmd_en && cmd_ready) begin
                @(posedge clk);
                model_cmd(CMD_WR, addr);
                acc++;
            end else begin
                @(posedge clk);
            end
            #1;
        end
        cmd_en = 1'b0;
        check("t5_accepted_before_full", acc, 4);
        check("t5_cmd_ready_full", cmd_ready, 0);
        fork
            begin
                for (int i = acc; i < 6; i++) send_cmd(CMD_WR, 28'h100 + ADDR_W'(i * 8));
            end
            begin
                for (int i = 0; i < 6; i++) send_data(rand128(), 16'h0000);
            end
        join
        for (int i = 0; i < 6; i++) send_cmd(CMD_RD, 28'h100 + ADDR_W'(i * 8));
        wait_drain();

        // Randomized mix over a small address set, cmds and data decoupled
        for (int j = 0; j < 16; j++) begin
            logic [ADDR_W-1:0] a;
            idx_tab[j] = 300 + j * 37;
            a = ADDR_W'($urandom);
            a[12:3] = idx_tab[j][9:0];
            send_data(rand128(), 16'h0000);
            send_cmd(CMD_WR, a);
        end
        for (int i = 0; i < 160; i++) begin
            int r;
            logic [ADDR_W-1:0] a;
            int sel;
            r   = $urandom_range(0, 9);
            sel = $urandom_range(0, 15);
            a   = ADDR_W'($urandom);
            a[12:3] = idx_tab[sel][9:0];
            op_a.push_back(a);
            if (r < 5) begin
                op_c.push_back(CMD_WR);
                wd_q.push_back(rand128());
                wm_q.push_back(($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
            end else if (r < 9) begin
                op_c.push_back(CMD_RD);
            end else begin
                op_c.push_back(3'($urandom_range(2, 7)));
            end
        end
        fork
            begin
                for (int i = 0; i < op_c.size(); i++) begin
                    send_cmd(op_c[i], op_a[i]);
                    idle($urandom_range(0, 2));
                end
            end
            begin
                for (int i = 0; i < wd_q.size(); i++) begin
                    send_data(wd_q[i], wm_q[i]);
                    idle($urandom_range(0, 3));
                end
            end
        join
        wait_drain();
        check("rand_model_cmds_left", mcmd_q.size(), 0);

        // Reset with two reads in flight
        send_cmd(CMD_RD, 28'h40);
        send_cmd(CMD_RD, 28'h80);
        rst = 1'b1;
        exp_q.delete();
        mcmd_q.delete();
        mdat_q.delete();
        mmsk_q.delete();
        idle(3);
        check_reset_outputs();
        rst = 1'b0;
        calib_check();
        check("post_rst_no_valid", rd_data_valid, 0);

        // Block RAM contents survive reset
        send_cmd(CMD_RD, 28'h40);
        wait_drain();
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
